// File: rtl/slv_guard_rst_ctrl.sv
// Slave-reset recovery controller: isolates the slave path, pulses its reset, waits for
// the acknowledge with bounded retries and clears the guard once the slave is back.
module slv_guard_rst_ctrl #(
  parameter int unsigned DrainCycles   = 4,
  parameter int unsigned RstHoldCycles = 16,
  parameter int unsigned AckTimeout    = 256,
  parameter int unsigned MaxRetries    = 3,
  parameter int unsigned RstCntWidth   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ctrl_ena_i,
  input  logic                   rst_req_i,
  input  logic                   slv_rst_ack_i,
  input  logic                   sw_clear_i,
  output logic                   guard_ena_o,
  output logic                   isolate_o,
  output logic                   slv_rst_no,
  output logic                   reset_clear_o,
  output logic                   busy_o,
  output logic                   fault_o,
  output logic [2:0]             state_o,
  output logic [RstCntWidth-1:0] rst_cnt_o
);

  localparam int unsigned MaxDh  = (DrainCycles > RstHoldCycles) ? DrainCycles : RstHoldCycles;
  localparam int unsigned MaxTmr = (MaxDh > AckTimeout) ? MaxDh : AckTimeout;
  localparam int unsigned TmrW   = $clog2(MaxTmr + 1);
  localparam int unsigned RetryW = $clog2(MaxRetries + 1);

  typedef enum logic [2:0] {
    StDisabled = 3'd0,
    StMonitor  = 3'd1,
    StIsolate  = 3'd2,
    StHold     = 3'd3,
    StWaitAck  = 3'd4,
    StClear    = 3'd5,
    StFault    = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [TmrW-1:0]        tmr_q, tmr_d;
  logic [RetryW-1:0]      retry_q, retry_d;
  logic [RetryW-1:0]      retry_inc;
  logic [RstCntWidth-1:0] rst_cnt_q, rst_cnt_d;
  logic                   tmr_last;

  assign retry_inc = retry_q + RetryW'(1);
  assign tmr_last  = (tmr_q == TmrW'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StDisabled;
      tmr_q     <= '0;
      retry_q   <= '0;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      retry_q   <= retry_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // The timer is reloaded on entry to each timed state and moves the FSM when it hits 1.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    retry_d   = retry_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      StDisabled: begin
        if (ctrl_ena_i) state_d = StMonitor;
      end
      StMonitor: begin
        if (rst_req_i) begin
          state_d = StIsolate;
          tmr_d   = TmrW'(DrainCycles);
        end else if (!ctrl_ena_i) begin
          state_d = StDisabled;
        end
      end
      StIsolate: begin
        if (tmr_last) begin
          state_d = StHold;
          tmr_d   = TmrW'(RstHoldCycles);
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      StHold: begin
        if (tmr_last) begin
          state_d = StWaitAck;
          tmr_d   = TmrW'(AckTimeout);
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      StWaitAck: begin
        // An ack in the timeout cycle still wins over the retry.
        if (slv_rst_ack_i) begin
          state_d = StClear;
        end else if (tmr_last) begin
          retry_d = retry_inc;
          if (retry_inc == RetryW'(MaxRetries)) begin
            state_d = StFault;
          end else begin
            state_d = StHold;
            tmr_d   = TmrW'(RstHoldCycles);
          end
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      StClear: begin
        retry_d = '0;
        if (rst_cnt_q != '1) rst_cnt_d = rst_cnt_q + RstCntWidth'(1);
        state_d = ctrl_ena_i ? StMonitor : StDisabled;
      end
      StFault: begin
        if (sw_clear_i) begin
          retry_d = '0;
          state_d = StDisabled;
        end
      end
      default: state_d = StDisabled;
    endcase
  end

  always_comb begin
    guard_ena_o   = 1'b0;
    isolate_o     = 1'b0;
    slv_rst_no    = 1'b1;
    reset_clear_o = 1'b0;
    busy_o        = 1'b0;
    fault_o       = 1'b0;
    case (state_q)
      StMonitor: guard_ena_o = 1'b1;
      StIsolate: begin
        isolate_o = 1'b1;
        busy_o    = 1'b1;
      end
      StHold: begin
        isolate_o  = 1'b1;
        slv_rst_no = 1'b0;
        busy_o     = 1'b1;
      end
      StWaitAck: begin
        isolate_o = 1'b1;
        busy_o    = 1'b1;
      end
      StClear: begin
        isolate_o     = 1'b1;
        reset_clear_o = 1'b1;
        busy_o        = 1'b1;
      end
      StFault: begin
        isolate_o = 1'b1;
        fault_o   = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o   = state_q;
  assign rst_cnt_o = rst_cnt_q;

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Scoreboard bench: stimulus queues the expected recovery/fault events, a monitor checks
// latency, reset-low and isolate durations when the DUT pulses reset_clear_o or enters FAULT.
module tb_slv_guard_rst_ctrl;

  localparam logic [2:0] SDis = 3'd0, SMon = 3'd1, SIso = 3'd2, SHold = 3'd3;
  localparam logic [2:0] SWait = 3'd4, SClr = 3'd5, SFault = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n, ctrl_ena, rst_req, ack, sw_clear;
  logic       guard_ena, isolate, slv_rst_n, reset_clear, busy, fault;
  logic [2:0] state;
  logic [1:0] rst_cnt;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit is_fault;
    int lat;
    int low;
    int iso;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  slv_guard_rst_ctrl #(
    .DrainCycles  (4),
    .RstHoldCycles(16),
    .AckTimeout   (256),
    .MaxRetries   (3),
    .RstCntWidth  (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ctrl_ena_i   (ctrl_ena),
    .rst_req_i    (rst_req),
    .slv_rst_ack_i(ack),
    .sw_clear_i   (sw_clear),
    .guard_ena_o  (guard_ena),
    .isolate_o    (isolate),
    .slv_rst_no   (slv_rst_n),
    .reset_clear_o(reset_clear),
    .busy_o       (busy),
    .fault_o      (fault),
    .state_o      (state),
    .rst_cnt_o    (rst_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    for (int i = 0; i < budget && state != s; i++) tick();
    check(name, int'(state), int'(s));
  endtask

  task automatic push(input bit f, input int lat, input int low, input int iso);
    exp_t e;
    e.is_fault = f;
    e.lat      = lat;
    e.low      = low;
    e.iso      = iso;
    exp_q.push_back(e);
  endtask

  // Monitor: cycle index 0 is the first negedge with isolate_o high.
  initial begin
    int   cyc = 0, seq_start = 0, low_cnt = 0, iso_cnt = 0;
    logic prev_iso = 1'b0, prev_fault = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (isolate && !prev_iso) begin
        seq_start = cyc;
        low_cnt   = 0;
        iso_cnt   = 0;
      end
      if (isolate) iso_cnt++;
      if (!slv_rst_n) low_cnt++;
      if (reset_clear || (fault && !prev_fault)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_is_fault", int'(fault), int'(e.is_fault));
          check("event_latency", cyc - seq_start, e.lat);
          check("slv_rst_low_cycles", low_cnt, e.low);
          check("isolate_cycles", iso_cnt, e.iso);
        end
      end
      prev_iso   = isolate;
      prev_fault = fault;
      cyc++;
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ctrl_ena = 1'b0; rst_req = 1'b0; ack = 1'b0; sw_clear = 1'b0;
    tick(2);
    check("rst_state", int'(state), 0);
    check("rst_guard_ena", int'(guard_ena), 0);
    check("rst_isolate", int'(isolate), 0);
    check("rst_slv_rst_n", int'(slv_rst_n), 1);
    check("rst_reset_clear", int'(reset_clear), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_cnt_reset", int'(rst_cnt), 0);
    rst_n = 1'b1;

    // Basic recovery with the ack tied high.
    ctrl_ena = 1'b1; ack = 1'b1;
    tick();
    check("enter_monitor", int'(state), int'(SMon));
    check("monitor_guard_ena", int'(guard_ena), 1);
    push(1'b0, 21, 16, 22);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    check("enter_isolate", int'(state), int'(SIso));
    check("isolate_busy", int'(busy), 1);
    check("isolate_guard_off", int'(guard_ena), 0);
    wait_state(SMon, 100, "back_to_monitor_1");
    check("rst_cnt_1", int'(rst_cnt), 1);

    // Request held high through CLEAR re-enters ISOLATE from the first MONITOR cycle.
    push(1'b0, 21, 16, 22);
    push(1'b0, 21, 16, 22);
    rst_req = 1'b1;
    tick();
    wait_state(SClr, 100, "reach_clear_2");
    tick();
    check("monitor_between", int'(state), int'(SMon));
    check("rst_cnt_2", int'(rst_cnt), 2);
    tick();
    check("reenter_isolate", int'(state), int'(SIso));
    rst_req = 1'b0;
    wait_state(SMon, 100, "back_to_monitor_3");
    check("rst_cnt_3", int'(rst_cnt), 3);

    // Request and disable together: request wins, disable takes effect after CLEAR.
    push(1'b0, 21, 16, 22);
    rst_req = 1'b1; ctrl_ena = 1'b0;
    tick();
    rst_req = 1'b0;
    check("req_wins_over_disable", int'(state), int'(SIso));
    wait_state(SDis, 100, "clear_to_disabled");
    check("disabled_guard_ena", int'(guard_ena), 0);
    check("rst_cnt_saturated", int'(rst_cnt), 3);

    // DISABLED ignores requests; sw_clear ignored outside FAULT.
    rst_req = 1'b1; sw_clear = 1'b1;
    tick(2);
    rst_req = 1'b0; sw_clear = 1'b0;
    check("disabled_ignores_req", int'(state), int'(SDis));

    // Ack never arrives: three rounds then FAULT.
    ctrl_ena = 1'b1; ack = 1'b0;
    tick();
    check("monitor_before_fault", int'(state), int'(SMon));
    push(1'b1, 820, 48, 821);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    wait_state(SFault, 1000, "reach_fault");
    tick(3);
    check("fault_sticky", int'(state), int'(SFault));
    check("fault_flag", int'(fault), 1);
    check("fault_isolate", int'(isolate), 1);
    check("fault_not_busy", int'(busy), 0);
    sw_clear = 1'b1;
    tick();
    sw_clear = 1'b0;
    check("sw_clear_state", int'(state), int'(SDis));
    check("sw_clear_fault", int'(fault), 0);
    check("fault_keeps_rst_cnt", int'(rst_cnt), 3);
    tick();
    check("monitor_after_fault", int'(state), int'(SMon));
    sw_clear = 1'b1;
    tick();
    sw_clear = 1'b0;
    check("monitor_ignores_sw_clear", int'(state), int'(SMon));

    // Ack lands exactly on the 256th WAIT_ACK cycle: CLEAR, no second HOLD.
    push(1'b0, 276, 16, 277);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    wait_state(SWait, 100, "reach_wait_ack");
    tick(255);
    check("still_waiting_at_256", int'(state), int'(SWait));
    ack = 1'b1;
    tick();
    check("ack_wins_timeout", int'(state), int'(SClr));
    wait_state(SMon, 10, "back_to_monitor_timeout_ack");

    // Reset in HOLD cycle 5 releases the slave reset with no clear pulse.
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    wait_state(SHold, 100, "reach_hold");
    tick(4);
    rst_n = 1'b0;
    tick();
    check("midrst_state", int'(state), 0);
    check("midrst_slv_rst_n", int'(slv_rst_n), 1);
    check("midrst_isolate", int'(isolate), 0);
    check("midrst_rst_cnt", int'(rst_cnt), 0);
    rst_n = 1'b1;
    tick(4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
